mem_port_arbiter: RTL and testbench

- Shares the single word-wide external memory port between the I-cache miss handler (line fills) and the D-cache miss/write handler (line fills and single-word write-through) of the pipelined TSC core.
- Sequences each line fill as LINE_WORDS back-to-back word reads and steers returned words to the owning cache.
- Gives the D-cache priority, because MEM stage instructions are older than IF stage instructions.
- Includes an anti-starvation limit so the I-cache always makes progress.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_priority.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the arbiter state and owner encodings and the default line geometry.
package mem_port_arbiter_pkg;

  localparam int LINE_WORDS = 4;
  localparam int IDX_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_GAP,
    WR_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arb_priority.sv
// IDLE-state winner selection for the memory port arbiter.
// The D-cache normally wins. A saturating starve counter tracks D grants
// made while the I-cache is waiting, and forces an I grant once it reaches
// STARVE_LIMIT.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   i_req, d_req      requests from the two cache miss handlers
//   state             arbiter state; grants are only produced in IDLE
//   grant_i, grant_d  one-hot winner for this edge (both 0 outside IDLE)
module mem_arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_req,
  input  logic       d_req,
  input  arb_state_t state,
  output logic       grant_i,
  output logic       grant_d
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          idle;
  logic          force_i;

  always_comb begin
    idle    = (state == IDLE);
    force_i = i_req && (starve_cnt == LIMIT);
    grant_d = idle && d_req && !force_i;
    grant_i = idle && i_req && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (!i_req || grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single word-wide memory port between the I-cache fill handler
// and the D-cache fill/write-through handler. Line fills are issued as
// LINE_WORDS single-word reads in fixed order 0..LINE_WORDS-1, with one
// strobe-low cycle between words. Returned words are steered to the owner.
//
// State table:
//   state   | meaning
//   IDLE    | no owner; arbitration happens at the edge
//   RD_WAIT | mem_read high, waiting for mem_ack on the current word
//   RD_GAP  | one strobe-low cycle before the next word of a fill
//   WR_WAIT | mem_write high, waiting for mem_ack on a D write
//
// Ports:
//   clk, reset_n                        clock, synchronous active-low reset
//   i_req, i_addr                       I-cache fill request and miss address
//   i_fill_valid, i_done                I-cache word strobe and last-word flag
//   d_req, d_we, d_addr, d_wdata        D-cache request (fill or single write)
//   d_fill_valid, d_done                D-cache word strobe and completion
//   fill_idx, rdata                     word index and data of returned word
//   mem_read, mem_write, mem_addr,
//   mem_wdata, mem_rdata, mem_ack       external memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int LINE_WORDS   = mem_port_arbiter_pkg::LINE_WORDS,
  parameter int IDX_W        = mem_port_arbiter_pkg::IDX_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_fill_valid,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_fill_valid,
  output logic                 d_done,
  output logic [IDX_W-1:0]     fill_idx,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);

  // Clears the word-index bits so a fill always starts at the line base.
  localparam logic [WORD_SIZE-1:0] LINE_MASK = ~WORD_SIZE'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(LINE_WORDS - 1);

  arb_state_t           state, state_nx;
  owner_t               owner, owner_nx;
  logic [IDX_W-1:0]     word_cnt, word_cnt_nx;
  logic                 mem_read_nx, mem_write_nx;
  logic [WORD_SIZE-1:0] mem_addr_nx, mem_wdata_nx;
  logic                 grant_i, grant_d;
  logic                 rd_ack, last_word;

  mem_arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_priority (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .d_req   (d_req),
    .state   (state),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      word_cnt  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      word_cnt  <= word_cnt_nx;
      mem_read  <= mem_read_nx;
      mem_write <= mem_write_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    word_cnt_nx  = word_cnt;
    mem_read_nx  = mem_read;
    mem_write_nx = mem_write;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;

    rd_ack       = (state == RD_WAIT) && mem_ack;
    last_word    = (word_cnt == LAST_IDX);
    i_fill_valid = rd_ack && (owner == OWN_I);
    d_fill_valid = rd_ack && (owner == OWN_D);
    i_done       = i_fill_valid && last_word;
    d_done       = (d_fill_valid && last_word) || ((state == WR_WAIT) && mem_ack);
    fill_idx     = word_cnt;
    rdata        = mem_rdata;

    unique case (state)
      IDLE: begin
        if (grant_d) begin
          owner_nx    = OWN_D;
          word_cnt_nx = '0;
          if (d_we) begin
            state_nx     = WR_WAIT;
            mem_write_nx = 1'b1;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
          end else begin
            state_nx    = RD_WAIT;
            mem_read_nx = 1'b1;
            mem_addr_nx = d_addr & LINE_MASK;
          end
        end else if (grant_i) begin
          owner_nx    = OWN_I;
          word_cnt_nx = '0;
          state_nx    = RD_WAIT;
          mem_read_nx = 1'b1;
          mem_addr_nx = i_addr & LINE_MASK;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          mem_read_nx = 1'b0;
          if (last_word) begin
            state_nx    = IDLE;
            owner_nx    = OWN_NONE;
            word_cnt_nx = '0;
          end else begin
            state_nx    = RD_GAP;
            word_cnt_nx = word_cnt + 1'b1;
          end
        end
      end
      RD_GAP: begin
        // word_cnt already points at the next word; the line base is kept in mem_addr.
        state_nx    = RD_WAIT;
        mem_read_nx = 1'b1;
        mem_addr_nx = (mem_addr & LINE_MASK) | WORD_SIZE'(word_cnt);
      end
      WR_WAIT: begin
        if (mem_ack) begin
          state_nx     = IDLE;
          owner_nx     = OWN_NONE;
          mem_write_nx = 1'b0;
        end
      end
      default: begin
        state_nx     = IDLE;
        owner_nx     = OWN_NONE;
        mem_read_nx  = 1'b0;
        mem_write_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level arbiter model
// pushes the expected memory beats into a queue at each grant; a monitor pops
// and compares whenever memory acknowledges a strobe.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int W  = 16;
  localparam int LW = 4;
  localparam int IW = 2;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_we;
  logic [W-1:0]  i_addr, d_addr, d_wdata;
  logic          i_fill_valid, i_done, d_fill_valid, d_done;
  logic [IW-1:0] fill_idx;
  logic [W-1:0]  rdata;
  logic          mem_read, mem_write;
  logic [W-1:0]  mem_addr, mem_wdata;
  logic [W-1:0]  mem_rdata = '0;
  logic          mem_ack   = 1'b0;

  mem_port_arbiter #(
    .WORD_SIZE(W), .LINE_WORDS(LW), .IDX_W(IW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_fill_valid(i_fill_valid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_fill_valid(d_fill_valid), .d_done(d_done),
    .fill_idx(fill_idx), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] data_of(logic [W-1:0] a);
    return (a * 16'd37) ^ 16'h5A3C;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    bit           wr;
    int           own;   // 1 = I-cache, 2 = D-cache
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           idx;
    bit           last;
  } exp_t;

  exp_t exp_q[$];
  bit   m_busy = 0;
  int   m_left = 0;
  int   m_starve = 0;
  bit   m_force;

  task automatic push_fill(int own, logic [W-1:0] a);
    exp_t e;
    logic [W-1:0] base;
    base = a - (a % 16'(LW));
    for (int k = 0; k < LW; k++) begin
      e.wr = 0; e.own = own; e.addr = base + 16'(k); e.wdata = '0;
      e.idx = k; e.last = (k == LW - 1);
      exp_q.push_back(e);
    end
    m_busy = 1; m_left = LW;
  endtask

  task automatic push_write(logic [W-1:0] a, logic [W-1:0] wd);
    exp_t e;
    e.wr = 1; e.own = 2; e.addr = a; e.wdata = wd; e.idx = 0; e.last = 1;
    exp_q.push_back(e);
    m_busy = 1; m_left = 1;
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete(); m_busy = 0; m_left = 0; m_starve = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else begin
      m_force = i_req && (m_starve == SL);
      if (d_req && !m_force) begin
        m_starve = i_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        if (d_we) push_write(d_addr, d_wdata);
        else      push_fill(2, d_addr);
      end else if (i_req) begin
        m_starve = 0;
        push_fill(1, i_addr);
      end else begin
        m_starve = 0;
      end
    end
  end

  // ---------------- memory responder ----------------
  int lat_fixed = 1;   // 0 = random latency 1..4
  int age = 0;
  int cur_lat = 1;
  bit stray_req = 0;

  always @(posedge clk) begin
    #2;
    if (stray_req) begin
      stray_req = 0; age = 0;
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    end else if (mem_read || mem_write) begin
      age++;
      if (age == 1) cur_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
      if (age == cur_lat) begin
        mem_ack = 1'b1;
        mem_rdata = mem_read ? data_of(mem_addr) : 16'($urandom);
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end else begin
      age = 0; mem_ack = 1'b0; mem_rdata = '0;
    end
  end

  // ---------------- requester agents ----------------
  bit i_hold = 0;
  bit d_hold = 0;

  always begin
    @(negedge clk);
    if (i_req && i_done) begin
      @(posedge clk); #1;
      if (i_hold) i_addr = 16'($urandom);
      else        i_req = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (d_req && d_done) begin
      @(posedge clk); #1;
      if (d_hold) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); end
      else        d_req = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_en = 0;
  int ack_seen = 0;
  int i_done_seen = 0;
  int d_since = 0;
  int run_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("strobe_excl", 32'(mem_read & mem_write), 0);
      if (!mem_ack) begin
        check("quiet", 32'({i_fill_valid, d_fill_valid, i_done, d_done}), 0);
      end else begin
        ack_seen++;
        if (exp_q.size() == 0) begin
          check("stray_ack", 32'({i_fill_valid, d_fill_valid, i_done, d_done}), 0);
        end else begin
          e = exp_q.pop_front();
          check("mem_addr",  32'(mem_addr),  32'(e.addr));
          check("mem_read",  32'(mem_read),  32'(!e.wr));
          check("mem_write", 32'(mem_write), 32'(e.wr));
          if (e.wr) begin
            check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            check("wr_flags", 32'({i_fill_valid, d_fill_valid, i_done, d_done}), 32'h1);
          end else begin
            check("i_fill_valid", 32'(i_fill_valid), 32'(e.own == 1));
            check("d_fill_valid", 32'(d_fill_valid), 32'(e.own == 2));
            check("fill_idx", 32'(fill_idx), e.idx);
            check("rdata", 32'(rdata), 32'(data_of(e.addr)));
            check("i_done", 32'(i_done), 32'(e.own == 1 && e.last));
            check("d_done", 32'(d_done), 32'(e.own == 2 && e.last));
          end
        end
      end
      if (d_done) d_since++;
      if (i_done) begin
        run_q.push_back(d_since);
        d_since = 0;
        i_done_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(int max);
    bit ok;
    ok = 0;
    for (int c = 0; c < max; c++) begin
      tick();
      if (!i_req && !d_req && !m_busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy want idle at %0t", $time);
      i_hold = 0; d_hold = 0; i_req = 0; d_req = 0; reset_n = 0;
      tick(); tick();
      reset_n = 1;
    end
    tick();
  endtask

  task automatic issue_i(logic [W-1:0] a);
    for (int c = 0; c < 500 && i_req; c++) tick();
    i_addr = a; i_req = 1'b1;
  endtask

  task automatic issue_d(logic we, logic [W-1:0] a, logic [W-1:0] wd);
    for (int c = 0; c < 500 && d_req; c++) tick();
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int saved;
    logic [6:0] rd_pat, dn_pat;

    reset_n = 0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_strobes", 32'({mem_read, mem_write}), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_outs", 32'({i_fill_valid, d_fill_valid, i_done, d_done}), 0);
    check("rst_fill_idx", 32'(fill_idx), 0);
    mon_en = 1;
    tick();
    reset_n = 1;
    tick();

    // single I fill, latency 3
    lat_fixed = 3;
    issue_i(16'h0123);
    wait_idle(300);

    // simultaneous: D fill first, exactly one idle cycle, then I fill
    lat_fixed = 0;
    i_addr = 16'h0200; d_we = 0; d_addr = 16'h0040; i_req = 1; d_req = 1;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (d_done) begin ok = 1; break; end
    end
    check("sim_d_done_seen", 32'(ok), 1);
    @(negedge clk);
    check("turnaround_idle", 32'({mem_read, mem_write}), 0);
    @(negedge clk);
    check("turnaround_read", 32'(mem_read), 1);
    check("turnaround_addr", 32'(mem_addr), 32'h0200);
    wait_idle(300);

    // D write
    lat_fixed = 2;
    issue_d(1'b1, 16'h0007, 16'hBEEF);
    wait_idle(100);

    // starvation: D writes held, I waiting; two rounds
    lat_fixed = 0;
    run_q.delete(); d_since = 0;
    i_hold = 1; d_hold = 1;
    i_addr = 16'h0300; d_we = 1; d_addr = 16'h0010; d_wdata = 16'h1111;
    i_req = 1; d_req = 1;
    for (int c = 0; c < 3000 && run_q.size() < 2; c++) @(negedge clk);
    i_hold = 0; d_hold = 0;
    check("starve_rounds", 32'(run_q.size() >= 2), 1);
    if (run_q.size() >= 2) begin
      check("starve_round0_d", run_q[0], SL);
      check("starve_round1_d", run_q[1], SL);
    end
    wait_idle(1000);

    // reset in the middle of an I fill
    lat_fixed = 2;
    saved = ack_seen;
    issue_i(16'h0356);
    for (int c = 0; c < 300 && ack_seen < saved + 2; c++) @(negedge clk);
    check("rst_mid_acks", 32'(ack_seen >= saved + 2), 1);
    saved = i_done_seen;
    tick();
    reset_n = 0; i_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_strobes", 32'({mem_read, mem_write}), 0);
    tick();
    reset_n = 1; stray_req = 1;
    @(negedge clk);
    check("stray_mem_ack", 32'(mem_ack), 1);
    check("stray_i_done", 32'(i_done), 0);
    tick();
    @(negedge clk);
    check("stray_stays_idle", 32'({mem_read, mem_write}), 0);
    check("rst_no_done", i_done_seen, saved);
    tick();
    issue_i(16'h0356);
    wait_idle(300);

    // back-to-back memory: ack in the first cycle of every strobe
    lat_fixed = 1;
    issue_i(16'h0A5C);
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      rd_pat[6-k] = mem_read;
      dn_pat[6-k] = i_done;
    end
    check("b2b_read_pattern", 32'(rd_pat), 32'b1010101);
    check("b2b_done_pattern", 32'(dn_pat), 32'b0000001);
    wait_idle(100);

    // random traffic with addresses scrambled while requests are held
    lat_fixed = 0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (i_req) i_addr = 16'($urandom);
      else if ($urandom_range(0, 5) == 0) begin i_addr = 16'($urandom); i_req = 1; end
      if (d_req) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); end
      else if ($urandom_range(0, 5) == 0) begin
        d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom); d_wdata = 16'($urandom); d_req = 1;
      end
    end
    wait_idle(2000);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
